add_tree_acc: RTL and testbench

- Parametrised successor of the systolic-array adder-tree wrapper.
- Reduces OP_CNT signed operands per beat through a pipelined binary adder tree with a configurable number of register stages.
- Adds a per-beat accumulate mode that sums tree results across a group of beats closed by `op_last`.
- Carries the valid/last/type side channel aligned with the data.
- Sits between the systolic-array column outputs and the pipeline output formatter.

---
 rtl/add_tree_acc.sv | 259 +++++++++++++++++++++++++
 tb/tb_add_tree_acc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_tree_acc.sv
// add_tree_acc: pipelined signed adder tree with per-beat group accumulation.
//
// Reduces OP_CNT signed operands per beat through a binary adder tree that is
// registered every LVL_PER_STG levels. Operand counts that are not a power of
// two are zero-padded. A final output stage either passes the tree sum
// through or accumulates it across a group of beats closed by op_last.
// Latency is T+1 enabled clocks, where T = ceil(clog2(OP_CNT)/LVL_PER_STG).
//
// Optional feature: define ADD_TREE_ACC_SAT_EN to clamp results that do not
// fit OUT_WDT and flag them on res_sat. Without it, narrowing wraps and
// res_sat is tied to 0.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clk_en    : global stall, all state holds while 0
//   op_data   : packed operands, operand i at [i*WORD_WDT +: WORD_WDT]
//   op_val    : per-operand valid; a beat is valid only if all bits are set
//   op_last   : last beat of an accumulation group
//   op_type   : data type carried alongside the beat
//   op_acc    : 1 = accumulate this beat, 0 = pass it through
//   res_data  : result
//   res_val   : result valid, one pulse per result
//   res_last  : result closes a group
//   res_type  : type of the beat that produced the result
//   res_sat   : result was clamped
//   acc_err   : sticky, a pass beat interrupted a partial accumulation
module add_tree_acc #(
    parameter int OP_CNT      = 8,
    parameter int WORD_WDT    = 16,
    parameter int LVL_PER_STG = 1,
    parameter int ACC_GUARD   = 8,
    parameter int OUT_WDT     = 32,
    parameter int TYPE_WDT    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [OP_CNT*WORD_WDT-1:0]   op_data,
    input  logic [OP_CNT-1:0]            op_val,
    input  logic                         op_last,
    input  logic [TYPE_WDT-1:0]          op_type,
    input  logic                         op_acc,
    output logic [OUT_WDT-1:0]           res_data,
    output logic                         res_val,
    output logic                         res_last,
    output logic [TYPE_WDT-1:0]          res_type,
    output logic                         res_sat,
    output logic                         acc_err
);

    localparam int LOG     = $clog2(OP_CNT);
    localparam int PAD     = 1 << LOG;
    localparam int SUM_WDT = WORD_WDT + LOG;
    localparam int ACC_WDT = SUM_WDT + ACC_GUARD;
    localparam int T       = (LOG + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int SC_WDT  = TYPE_WDT + 3;

    // ------------------------------------------------------------------
    // Adder tree. Level 0 holds the sign-extended (padded) operands; each
    // level l halves the node count. A level is registered when it closes
    // a group of LVL_PER_STG levels or is the root.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= LOG; l++) begin : g_lvl
        localparam int N = PAD >> l;
        logic signed [SUM_WDT-1:0] node [N];

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < OP_CNT) begin
                        node[i] = SUM_WDT'($signed(op_data[i*WORD_WDT +: WORD_WDT]));
                    end else begin
                        node[i] = '0;
                    end
                end
            end
        end else begin : g_add
            logic signed [SUM_WDT-1:0] add [N];

            always_comb begin
                for (int unsigned i = 0; i < N; i++) begin
                    add[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
                end
            end

            if (((l % LVL_PER_STG) == 0) || (l == LOG)) begin : g_reg
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            node[i] <= '0;
                        end
                    end else if (clk_en) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            node[i] <= add[i];
                        end
                    end
                end
            end else begin : g_comb
                always_comb begin
                    for (int unsigned i = 0; i < N; i++) begin
                        node[i] = add[i];
                    end
                end
            end
        end
    end

    logic signed [SUM_WDT-1:0] tree_sum;
    assign tree_sum = g_lvl[LOG].node[0];

    // ------------------------------------------------------------------
    // Side channel, T deep so it lines up with the tree root register.
    // ------------------------------------------------------------------
    logic [SC_WDT-1:0] sc_in;
    logic [SC_WDT-1:0] sc_q [T];
    logic              d_val;
    logic              d_last;
    logic              d_acc;
    logic [TYPE_WDT-1:0] d_type;

    assign sc_in = {&op_val, op_last, op_acc, op_type};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < T; i++) begin
                sc_q[i] <= '0;
            end
        end else if (clk_en) begin
            sc_q[0] <= sc_in;
            for (int unsigned i = 1; i < T; i++) begin
                sc_q[i] <= sc_q[i-1];
            end
        end
    end

    assign {d_val, d_last, d_acc, d_type} = sc_q[T-1];

    // ------------------------------------------------------------------
    // Accumulator datapath and result narrowing.
    // ------------------------------------------------------------------
    typedef enum logic {
        ACC_IDLE,
        ACC_BUSY
    } acc_state_e;

    acc_state_e state_q;
    acc_state_e state_nxt;
    logic       acc_busy;

    logic signed [ACC_WDT-1:0] sum_ext;
    logic signed [ACC_WDT-1:0] acc_q;
    logic signed [ACC_WDT-1:0] acc_upd;
    logic signed [ACC_WDT-1:0] out_pre;
    logic [OUT_WDT-1:0]        red_data;
    logic                      red_sat;

    assign acc_busy = (state_q == ACC_BUSY);
    assign sum_ext  = ACC_WDT'(tree_sum);
    assign acc_upd  = acc_busy ? (acc_q + sum_ext) : sum_ext;
    assign out_pre  = d_acc ? acc_upd : sum_ext;

    if (OUT_WDT >= ACC_WDT) begin : g_ext
        assign red_data = OUT_WDT'(out_pre);
        assign red_sat  = 1'b0;
    end else begin : g_narrow
`ifdef ADD_TREE_ACC_SAT_EN
        // Value fits when every bit from the OUT_WDT sign bit upward agrees.
        logic [ACC_WDT-OUT_WDT:0] top;
        assign top      = out_pre[ACC_WDT-1:OUT_WDT-1];
        assign red_sat  = !((&top) || !(|top));
        assign red_data = !red_sat       ? out_pre[OUT_WDT-1:0] :
                          out_pre[ACC_WDT-1] ? {1'b1, {(OUT_WDT-1){1'b0}}} :
                                               {1'b0, {(OUT_WDT-1){1'b1}}};
`else
        logic unused_hi;
        assign unused_hi = ^out_pre[ACC_WDT-1:OUT_WDT];
        assign red_data  = out_pre[OUT_WDT-1:0];
        assign red_sat   = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC_IDLE;
        end else if (clk_en) begin
            state_q <= state_nxt;
        end
    end

    // Next state: only an accumulate beat without last leaves a partial pending.
    always_comb begin
        state_nxt = state_q;
        if (d_val) begin
            if (d_acc && !d_last) begin
                state_nxt = ACC_BUSY;
            end else begin
                state_nxt = ACC_IDLE;
            end
        end
    end

    // Output / datapath next values
    logic signed [ACC_WDT-1:0] acc_nxt;
    logic                      err_nxt;
    logic                      val_nxt;
    logic                      last_nxt;
    logic [OUT_WDT-1:0]        data_nxt;
    logic [TYPE_WDT-1:0]       type_nxt;
    logic                      sat_nxt;

    always_comb begin
        acc_nxt  = acc_q;
        err_nxt  = acc_err;
        val_nxt  = 1'b0;
        last_nxt = 1'b0;
        data_nxt = res_data;
        type_nxt = res_type;
        sat_nxt  = res_sat;
        if (d_val) begin
            if (d_acc && !d_last) begin
                acc_nxt = acc_upd;
            end else begin
                // Group close or pass beat: emit and leave the accumulator
                // empty; a pass beat also drops any pending partial.
                acc_nxt  = '0;
                val_nxt  = 1'b1;
                last_nxt = d_last;
                data_nxt = red_data;
                type_nxt = d_type;
                sat_nxt  = red_sat;
                if (!d_acc && acc_busy) begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            acc_err  <= 1'b0;
            res_val  <= 1'b0;
            res_last <= 1'b0;
            res_data <= '0;
            res_type <= '0;
            res_sat  <= 1'b0;
        end else if (clk_en) begin
            acc_q    <= acc_nxt;
            acc_err  <= err_nxt;
            res_val  <= val_nxt;
            res_last <= last_nxt;
            res_data <= data_nxt;
            res_type <= type_nxt;
            res_sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_add_tree_acc.sv
module tb_add_tree_acc;

    localparam int OP_CNT    = 4;
    localparam int WORD_WDT  = 8;
    localparam int LVL       = 1;
    localparam int ACC_GUARD = 8;
    localparam int OUT_WDT   = 8;
    localparam int TYPE_WDT  = 2;
    localparam int LOG       = 2;
    localparam int ACC_WDT   = WORD_WDT + LOG + ACC_GUARD;
    localparam int LAT       = (LOG + LVL - 1) / LVL + 1;

    logic                       clk;
    logic                       rst;
    logic                       clk_en;
    logic [OP_CNT*WORD_WDT-1:0] op_data;
    logic [OP_CNT-1:0]          op_val;
    logic                       op_last;
    logic [TYPE_WDT-1:0]        op_type;
    logic                       op_acc;
    logic [OUT_WDT-1:0]         res_data;
    logic                       res_val;
    logic                       res_last;
    logic [TYPE_WDT-1:0]        res_type;
    logic                       res_sat;
    logic                       acc_err;

    add_tree_acc #(
        .OP_CNT      (OP_CNT),
        .WORD_WDT    (WORD_WDT),
        .LVL_PER_STG (LVL),
        .ACC_GUARD   (ACC_GUARD),
        .OUT_WDT     (OUT_WDT),
        .TYPE_WDT    (TYPE_WDT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .op_data  (op_data),
        .op_val   (op_val),
        .op_last  (op_last),
        .op_type  (op_type),
        .op_acc   (op_acc),
        .res_data (res_data),
        .res_val  (res_val),
        .res_last (res_last),
        .res_type (res_type),
        .res_sat  (res_sat),
        .acc_err  (acc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     last;
        int     typ;
        bit     sat;
        bit     err;
        int     at_edge;
    } exp_t;

    exp_t   q[$];
    int     checks   = 0;
    int     failures = 0;
    int     en_edges = 0;
    bit     en_prev  = 1'b0;

    // Reference model state: plain integers, wrapped to the accumulator width.
    longint m_acc  = 0;
    bit     m_busy = 1'b0;
    bit     m_err  = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap(input longint x, input int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic push(input longint v, input bit last, input int typ);
        exp_t   e;
        longint hi;
        longint lo;
        hi = (longint'(1) << (OUT_WDT - 1)) - 1;
        lo = -(longint'(1) << (OUT_WDT - 1));
`ifdef ADD_TREE_ACC_SAT_EN
        if (v > hi) begin
            e.data = hi; e.sat = 1'b1;
        end else if (v < lo) begin
            e.data = lo; e.sat = 1'b1;
        end else begin
            e.data = v;  e.sat = 1'b0;
        end
`else
        e.data = wrap(v, OUT_WDT);
        e.sat  = 1'b0;
`endif
        e.last    = last;
        e.typ     = typ;
        e.err     = m_err;
        e.at_edge = en_edges + LAT;
        q.push_back(e);
    endtask

    task automatic model(input int ops[4], input logic [3:0] v, input bit last,
                         input int typ, input bit acc);
        longint s;
        longint nv;
        if (v != 4'hF) return;
        s = 0;
        foreach (ops[i]) s += ops[i];
        if (!acc) begin
            if (m_busy) begin
                m_err  = 1'b1;
                m_busy = 1'b0;
                m_acc  = 0;
            end
            push(s, last, typ);
        end else begin
            nv = m_busy ? wrap(m_acc + s, ACC_WDT) : s;
            if (last) begin
                m_acc  = 0;
                m_busy = 1'b0;
                push(nv, 1'b1, typ);
            end else begin
                m_acc  = nv;
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic beat(input int o0, input int o1, input int o2, input int o3,
                        input logic [3:0] v, input bit last, input int typ,
                        input bit acc, input bit en);
        int ops[4];
        int t;
        ops = '{o0, o1, o2, o3};
        for (int i = 0; i < 4; i++) begin
            t = ops[i];
            op_data[i*WORD_WDT +: WORD_WDT] = t[7:0];
        end
        op_val  = v;
        op_last = last;
        op_type = typ[TYPE_WDT-1:0];
        op_acc  = acc;
        clk_en  = en;
        if (en) model(ops, v, last, typ, acc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(0, 0, 0, 0, 4'h0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_val"},  res_val,  0);
        check({tag, "_res_last"}, res_last, 0);
        check({tag, "_res_type"}, res_type, 0);
        check({tag, "_res_sat"},  res_sat,  0);
        check({tag, "_acc_err"},  acc_err,  0);
    endtask

    always @(posedge clk) begin
        en_prev = clk_en && !rst;
        if (en_prev) en_edges++;
    end

    // Monitor: after each enabled edge, a result is due iff the head of the
    // scoreboard is scheduled for this edge.
    always @(negedge clk) begin
        exp_t e;
        if (en_prev) begin
            if (q.size() > 0 && q[0].at_edge == en_edges) begin
                e = q.pop_front();
                check("res_val",  res_val, 1);
                check("res_data", $signed(res_data), e.data);
                check("res_last", res_last, e.last);
                check("res_type", res_type, e.typ);
                check("res_sat",  res_sat, e.sat);
                check("acc_err",  acc_err, e.err);
            end else begin
                check("res_val_idle", res_val, 0);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        clk_en  = 1'b0;
        op_data = '0;
        op_val  = '0;
        op_last = 1'b0;
        op_type = '0;
        op_acc  = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pass mode
        beat(1, 2, 3, 4, 4'hF, 1'b1, 2, 1'b0, 1'b1);
        idle(3);

        // Three-beat accumulate group
        beat(-1, -1, -1, -1, 4'hF, 1'b0, 1, 1'b1, 1'b1);
        beat(-1, -1, -1, -1, 4'hF, 1'b0, 1, 1'b1, 1'b1);
        beat(-1, -1, -1, -1, 4'hF, 1'b1, 3, 1'b1, 1'b1);
        idle(3);

        // Bubble mid-group plus a four-cycle stall
        beat(1, 1, 1, 1, 4'hF, 1'b0, 0, 1'b1, 1'b1);
        beat(9, 9, 9, 9, 4'hE, 1'b0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) beat(50, 50, 50, 50, 4'hF, 1'b1, 1, 1'b0, 1'b0);
        beat(2, 2, 2, 2, 4'hF, 1'b1, 2, 1'b1, 1'b1);
        idle(3);

        // Saturation / wrap on narrowing
        beat(127, 127, 127, 127, 4'hF, 1'b0, 1, 1'b1, 1'b1);
        beat(127, 127, 127, 127, 4'hF, 1'b1, 1, 1'b1, 1'b1);
        idle(3);

        // Mode switch with a partial pending
        beat(3, 3, 3, 3, 4'hF, 1'b0, 0, 1'b1, 1'b1);
        beat(3, 3, 3, 3, 4'hF, 1'b0, 0, 1'b1, 1'b1);
        beat(5, 0, 0, 0, 4'hF, 1'b0, 3, 1'b0, 1'b1);
        idle(3);
        check("acc_err_sticky", acc_err, 1);

        // Asynchronous reset with a partial pending and beats in flight
        beat(7, 7, 7, 7, 4'hF, 1'b0, 0, 1'b1, 1'b1);
        beat(6, 6, 6, 6, 4'hF, 1'b0, 2, 1'b0, 1'b1);
        beat(4, 4, 4, 4, 4'hF, 1'b0, 0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        q.delete();
        m_acc  = 0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(1, 2, 3, 4, 4'hF, 1'b1, 1, 1'b1, 1'b1);
        idle(3);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int o[4];
            logic [3:0] v;
            bit big;
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++)
                o[i] = big ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
            v = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            beat(o[0], o[1], o[2], o[3], v, ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0));
        end

        // Drain with a bounded wait
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
        check("drain_pending", q.size(), 0);
        check("acc_err_final", acc_err, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
